// File: rtl/ncl_threshold_gate_bank.sv
// Registered NCL threshold gate bank: WIDTH lanes each of TH12, TH22 (hysteresis)
// and THnotN (inverting, reset-to-NULL). Each gate evaluates one wavefront step per clock.
module ncl_threshold_gate_bank #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] th12_a,
  input  logic [WIDTH-1:0] th12_b,
  output logic [WIDTH-1:0] th12_y,
  input  logic [WIDTH-1:0] th22_a,
  input  logic [WIDTH-1:0] th22_b,
  output logic [WIDTH-1:0] th22_y,
  input  logic [WIDTH-1:0] thn_a,
  output logic [WIDTH-1:0] thn_y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic th12_q;
    logic th22_q;
    logic thn_q;

    // NOTE: registered state is always written with non-blocking assignments so
    // every lane samples pre-edge values, which keeps external feedback loops race-free.
    always_ff @(posedge clk) begin
      if (init) th12_q <= 1'b0;
      else      th12_q <= th12_a[i] | th12_b[i];
    end

    // TH22 only changes when both inputs agree; otherwise the held value is kept.
    always_ff @(posedge clk) begin
      if (init)                        th22_q <= 1'b0;
      else if (th22_a[i] & th22_b[i])  th22_q <= 1'b1;
      else if (~th22_a[i] & ~th22_b[i]) th22_q <= 1'b0;
    end

    // Init forces NULL even though the gate inverts, so a released pipeline
    // produces its first DATA wavefront one edge after init drops.
    always_ff @(posedge clk) begin
      if (init) thn_q <= 1'b0;
      else      thn_q <= ~thn_a[i];
    end

    assign th12_y[i] = th12_q;
    assign th22_y[i] = th22_q;
    assign thn_y[i]  = thn_q;
  end

endmodule

// File: tb/tb_ncl_threshold_gate_bank.sv
// Directed bench for ncl_threshold_gate_bank: expected outputs are queued when a step is
// driven and popped/compared one edge later, plus directed per-lane checks.
module tb_ncl_threshold_gate_bank;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         init = 1'b0;
  logic [W-1:0] th12_a = '0, th12_b = '0, th12_y;
  logic [W-1:0] th22_a = '0, th22_b = '0, th22_y;
  logic [W-1:0] thn_a = '0, thn_y;

  always #5 clk = ~clk;

  ncl_threshold_gate_bank #(.WIDTH(W)) dut (
    .clk(clk), .init(init),
    .th12_a(th12_a), .th12_b(th12_b), .th12_y(th12_y),
    .th22_a(th22_a), .th22_b(th22_b), .th22_y(th22_y),
    .thn_a(thn_a), .thn_y(thn_y)
  );

  typedef struct {
    logic [W-1:0] y12;
    logic [W-1:0] y22;
    logic [W-1:0] yn;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m22 = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the model's prediction, then compare after the edge.
  task automatic step(input logic i, input logic [W-1:0] a12, input logic [W-1:0] b12,
                      input logic [W-1:0] a22, input logic [W-1:0] b22, input logic [W-1:0] an);
    exp_t e;
    init = i; th12_a = a12; th12_b = b12; th22_a = a22; th22_b = b22; thn_a = an;
    e.y12 = i ? '0 : (a12 | b12);
    e.y22 = i ? '0 : ((a22 & b22) | (m22 & (a22 | b22)));
    e.yn  = i ? '0 : ~an;
    m22 = e.y22;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("th12_y", th12_y, e.y12);
    check("th22_y", th22_y, e.y22);
    check("thn_y", thn_y, e.yn);
  endtask

  logic [W-1:0] l3;
  logic [1:0]   pat [4];
  logic         exp_bit [6];
  logic [1:0]   pat22 [6];
  logic [W-1:0] rt, rf;

  initial begin
    l3 = W'(8);

    // Reset with random inputs.
    for (int k = 0; k < 3; k++)
      step(1'b1, W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()));
    check("reset_th22", th22_y, '0);
    step(1'b0, '0, '0, '0, '0, '0);
    check("release_thn", thn_y, '1);

    // TH12 truth table on lane 0.
    pat = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, W'(pat[k][1]), W'(pat[k][0]), '0, '0, '0);
      check("th12_l0", W'(th12_y[0]), W'(k != 0));
    end

    // TH22 hysteresis on lane 3.
    pat22   = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
    exp_bit = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, '0, pat22[k][1] ? l3 : '0, pat22[k][0] ? l3 : '0, '0);
      check("th22_l3", W'(th22_y[3]), W'(exp_bit[k]));
    end
    step(1'b0, '0, '0, l3, l3, '0);
    check("th22_l3_set", W'(th22_y[3]), W'(1));
    step(1'b1, '0, '0, l3, '0, '0);
    check("th22_l3_init", W'(th22_y[3]), W'(0));
    step(1'b0, '0, '0, l3, '0, '0);
    check("th22_l3_post", W'(th22_y[3]), W'(0));

    // THnotN oscillator: thn_y[0] fed back to thn_a[0].
    step(1'b1, '0, '0, '0, '0, W'(thn_y[0]));
    step(1'b1, '0, '0, '0, '0, W'(thn_y[0]));
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, '0, '0, '0, W'(thn_y[0]));
      check("osc_l0", W'(thn_y[0]), W'(k % 2 == 0));
    end
    step(1'b1, '0, '0, '0, '0, W'(thn_y[0]));
    check("osc_init", W'(thn_y[0]), W'(0));
    step(1'b1, '0, '0, '0, '0, W'(thn_y[0]));
    check("osc_hold", W'(thn_y[0]), W'(0));

    // Lane independence.
    step(1'b0, '0, '0, '0, '0, '0);
    step(1'b0, '0, '0, 32'hFFFF0000, 32'hFF00FF00, '0);
    check("indep_data", th22_y, 32'hFF000000);
    step(1'b0, '0, '0, '0, '0, '0);
    check("indep_null", th22_y, '0);

    // Completion loop: TH12 per dual-rail digit, TH22 closure of both completions.
    step(1'b1, '0, '0, '0, '0, '0);
    exp_bit = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      rt = '0;
      rf = '0;
      if (k >= 0 && k <= 2) rt[0] = 1'b1;
      if (k >= 1 && k <= 3) rf[1] = 1'b1;
      if (k >= 4) begin rt = '0; rf = '0; end
      step(1'b0, rt, rf, W'(th12_y[0]), W'(th12_y[1]), '0);
      check("closure", W'(th22_y[0]), W'(exp_bit[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ncl_threshold_gate_bank.md
Name: ncl_threshold_gate_bank

Overview:
- Clocked, synthesizable model of the three NCL threshold gates used by the digit-pipelined counter: TH12 (1-of-2), TH22 (2-of-2 with hysteresis), and THnotN (inverting, reset-to-NULL).
- Each gate type is a bank of WIDTH independent lanes.
- Every gate output is registered, so NCL feedback loops built from these gates (completion, auto-consume, auto-produce) evaluate one wavefront step per clock.
- The block sits under the counter ring stages and the completion-detection trees.

Parameters:
- WIDTH, 32, number of independent lanes per gate type (minimum 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- init  input  1  synchronous active-high reset (NCL init); forces every output to NULL (0).
- th12_a  input  WIDTH  TH12 input A, per lane.
- th12_b  input  WIDTH  TH12 input B, per lane.
- th12_y  output  WIDTH  TH12 registered output.
- th22_a  input  WIDTH  TH22 input A, per lane.
- th22_b  input  WIDTH  TH22 input B, per lane.
- th22_y  output  WIDTH  TH22 registered output (hysteresis state).
- thn_a  input  WIDTH  THnotN input, per lane.
- thn_y  output  WIDTH  THnotN registered output.

Behaviour:
- All outputs are registers updated on the rising edge of clk. Latency is 1 cycle from an input change to the output change. No combinational path from input to output.
- init=1 at an edge: th12_y, th22_y and thn_y all become 0 at that edge. This overrides every other rule. init asserted mid-operation behaves identically and discards the TH22 held state.
- Lanes are fully independent. Lane i uses only bit i of its own inputs.
- TH12, per lane, init=0: next y = a OR b. No state; 1 when at least one input is asserted.
- TH22, per lane, init=0:
  - a=1, b=1: next y = 1 (DATA).
  - a=0, b=0: next y = 0 (NULL).
  - a≠b: next y holds its current value (hysteresis).
- THnotN, per lane, init=0: next y = NOT a.
- THnotN, per lane, init=1: y = 0. This is the "N" (reset-to-NULL) variant, used as the auto-produce source of a pipeline.
- After init deasserts, a THnotN lane with thn_a=0 drives 1 on the first following edge.
- No X-propagation handling is required beyond plain RTL semantics. All outputs are defined from the first init edge onward.
- Inputs are sampled only at clock edges. Glitches between edges have no effect.
- The implementation uses generate loops over WIDTH lanes, one always block per gate type, and no latches.

Test Plan:
- Reset: drive random inputs with init=1 for 3 cycles -> all outputs 0 on every lane. Release init with thn_a=0 -> thn_y becomes all ones one edge later; th12_y and th22_y follow the inputs per their rules.
- TH12 truth table: apply lane0 (a,b) = 00, 01, 10, 11 on successive cycles -> th12_y[0] = 0, 1, 1, 1, each one cycle after the corresponding input.
- TH22 hysteresis:
  - Apply the sequence 00, 10, 11, 01, 00, 01 on lane 3 -> th22_y[3] = 0, 0, 1, 1, 0, 0 (lagging one cycle).
  - Repeat with 11 applied, then init pulsed while holding 10 -> output drops to 0 and stays 0 after init releases.
- THnotN oscillator: connect thn_y[0] back to thn_a[0] externally and pulse init for 2 cycles, then release -> thn_y[0] toggles 1, 0, 1, 0… every edge. Assert init again -> 0 on the next edge and held.
- Lane independence (WIDTH=32): apply th22 a=32'hFFFF0000, b=32'hFF00FF00 after an all-zero state -> th22_y=32'hFF000000. Then a=b=0 -> th22_y=0. No cross-lane interaction.
- Completion loop: build a 2-lane TH12 -> TH22 handshake (TH22 closure of two TH12 completions, as in the counter). Drive DATA on both rails, then NULL -> the closure output goes 1 only after both completions assert and returns to 0 only after both deassert, with the expected one-cycle-per-gate latency.
